// File: rtl/ekf_slam_pkg.sv
// Shared EKF-SLAM codes: association status, map command types and the
// association scheduler state encoding, plus the post-settle command decision.
package ekf_slam_pkg;

  localparam logic [1:0] ASSOC_WAIT = 2'b00;
  localparam logic [1:0] ASSOC_NEW  = 2'b01;
  localparam logic [1:0] ASSOC_UPD  = 2'b10;
  localparam logic [1:0] ASSOC_FAIL = 2'b11;

  localparam logic [1:0] CMD_NEW  = 2'b01;
  localparam logic [1:0] CMD_UPD  = 2'b10;
  localparam logic [1:0] CMD_DROP = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_ISSUE  = 3'd4;

  // Map command implied by the settled association status.
  // A NEW result on a full map cannot be stored, so it is dropped.
  function automatic logic [1:0] settle_cmd(input logic [1:0] status, input logic full);
    case (status)
      ASSOC_UPD: return CMD_UPD;
      ASSOC_NEW: return full ? CMD_DROP : CMD_NEW;
      default:   return CMD_DROP;
    endcase
  endfunction

endpackage

// File: rtl/assoc_lk_scheduler_if.sv
// Observation / association-engine / map-command handshakes of the scheduler.
// master = scheduler side, slave = environment side.
interface assoc_lk_scheduler_if #(parameter int ROW_LEN = 10);
  logic               obs_valid;
  logic               obs_ready;
  logic               assoc_start;
  logic               assoc_done;
  logic [ROW_LEN-1:0] l_k;
  logic [1:0]         assoc_status;
  logic [ROW_LEN-1:0] assoc_l_k;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [ROW_LEN-1:0] cmd_l_k;

  modport master (
    input  obs_valid, assoc_done, assoc_status, assoc_l_k, cmd_ready,
    output obs_ready, assoc_start, l_k, cmd_valid, cmd_type, cmd_l_k
  );

  modport slave (
    output obs_valid, assoc_done, assoc_status, assoc_l_k, cmd_ready,
    input  obs_ready, assoc_start, l_k, cmd_valid, cmd_type, cmd_l_k
  );
endinterface

// File: rtl/assoc_lk_scheduler_watchdog.sv
// assoc_watchdog: counts consecutive enabled cycles without a kick and flags
// expiry on the TIMEOUT_CYC-th such cycle. Leaving the enabled state clears it.
module assoc_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expired = en && !kick && (cnt == CW'(TIMEOUT_CYC - 1));

  // Idle-cycle counter; restarts on kick, on expiry and whenever disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (!en || kick || expired) cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/assoc_lk_scheduler.sv
// assoc_lk_scheduler: per observation, sweeps l_k over all stored landmarks
// (one assoc_start per index), waits for the chi-square result to settle and
// issues one map command (NEW / UPD / DROP). Owns the landmark count.
// Optional feature macro: ASSOC_TIMEOUT_EN (assoc_done watchdog, assoc_err).
module assoc_lk_scheduler
  import ekf_slam_pkg::*;
#(
  parameter int ROW_LEN     = 10,
  parameter int MAX_LM      = 16,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 lm_clear,
  assoc_lk_scheduler_if.master bus,
  output logic [ROW_LEN-1:0]   lm_num,
  output logic                 map_full,
  output logic                 assoc_err
);
  localparam int                 SW       = $clog2(SETTLE_CYC + 1);
  localparam logic [ROW_LEN-1:0] MAX_LM_V = ROW_LEN'(MAX_LM);

  logic [2:0]         state;
  logic [SW-1:0]      settle_cnt;
  logic               wd_expired;
  logic [1:0]         sel_type;
  logic [ROW_LEN-1:0] sel_l_k;

`ifdef ASSOC_TIMEOUT_EN
  assoc_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .en      (state == ST_SCAN),
    .kick    (bus.assoc_done),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Command and target chosen from the settled association result.
  always_comb begin
    sel_type = settle_cmd(bus.assoc_status, map_full);
    sel_l_k  = '0;
    case (sel_type)
      CMD_UPD: sel_l_k = bus.assoc_l_k;
      CMD_NEW: sel_l_k = lm_num + ROW_LEN'(1);
      default: sel_l_k = '0;
    endcase
  end

  // Scheduler FSM; every output is a register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      bus.obs_ready   <= 1'b0;
      bus.assoc_start <= 1'b0;
      bus.l_k         <= '0;
      bus.cmd_valid   <= 1'b0;
      bus.cmd_type    <= 2'b00;
      bus.cmd_l_k     <= '0;
      lm_num          <= '0;
      map_full        <= 1'b0;
      assoc_err       <= 1'b0;
    end else begin
      bus.assoc_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lm_clear) begin
            lm_num        <= '0;
            map_full      <= 1'b0;
            bus.obs_ready <= 1'b0;
          end else if (bus.obs_valid && bus.obs_ready) begin
            bus.obs_ready <= 1'b0;
            state         <= ST_CHECK;
          end else begin
            bus.obs_ready <= 1'b1;
          end
        end
        ST_CHECK: begin
          bus.l_k <= ROW_LEN'(1);
          if (lm_num == '0) begin
            // Empty map: nothing to associate against, seed landmark 1.
            bus.cmd_type  <= CMD_NEW;
            bus.cmd_l_k   <= ROW_LEN'(1);
            bus.cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end else begin
            bus.assoc_start <= 1'b1;
            state           <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (wd_expired) begin
            assoc_err     <= 1'b1;
            bus.cmd_type  <= CMD_DROP;
            bus.cmd_l_k   <= '0;
            bus.l_k       <= '0;
            bus.cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end else if (bus.assoc_done) begin
            if (bus.l_k < lm_num) begin
              bus.l_k         <= bus.l_k + ROW_LEN'(1);
              bus.assoc_start <= 1'b1;
            end else begin
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            bus.cmd_type  <= sel_type;
            bus.cmd_l_k   <= sel_l_k;
            bus.l_k       <= sel_l_k;
            bus.cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_ISSUE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            bus.obs_ready <= 1'b1;
            if (bus.cmd_type == CMD_NEW && !map_full) begin
              lm_num   <= lm_num + ROW_LEN'(1);
              map_full <= (lm_num + ROW_LEN'(1)) == MAX_LM_V;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_lk_scheduler.sv
// Bench for assoc_lk_scheduler: directed scenarios followed by random
// observations, checked against a transaction-level map model.
module tb_assoc_lk_scheduler;
  import ekf_slam_pkg::*;

  localparam int ROW_LEN     = 10;
  localparam int MAX_LM      = 4;
  localparam int SETTLE_CYC  = 2;
  localparam int TIMEOUT_CYC = 40;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic lm_clear = 1'b0;
  logic [ROW_LEN-1:0] lm_num;
  logic map_full, assoc_err;

  assoc_lk_scheduler_if #(.ROW_LEN(ROW_LEN)) bus();

  assoc_lk_scheduler #(
    .ROW_LEN(ROW_LEN), .MAX_LM(MAX_LM), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .lm_clear(lm_clear), .bus(bus),
    .lm_num(lm_num), .map_full(map_full), .assoc_err(assoc_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  int m_lm = 0;
  bit m_ready = 1'b0;
  bit check_en = 1'b0;
  bit held = 1'b0;
  logic [1:0] h_type;
  logic [ROW_LEN-1:0] h_lk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en && sys_rst_n) begin
      chk("lm_num", lm_num, m_lm);
      chk("map_full", map_full, int'(m_lm == MAX_LM));
      chk("obs_ready", bus.obs_ready, m_ready);
`ifndef ASSOC_TIMEOUT_EN
      chk("assoc_err", assoc_err, 0);
`endif
      if (held) begin
        chk("cmd_hold_valid", bus.cmd_valid, 1);
        chk("cmd_hold_type", bus.cmd_type, h_type);
        chk("cmd_hold_l_k", bus.cmd_l_k, h_lk);
      end
      held   = bus.cmd_valid && !bus.cmd_ready;
      h_type = bus.cmd_type;
      h_lk   = bus.cmd_l_k;
    end
  end

  // One observation end to end: expected command comes from the map rules.
  task automatic run_obs(input logic [1:0] st, input int alk, input int rdy_dly,
                         output logic [1:0] got_type, output int got_lk);
    logic [1:0] et;
    int el, exp_starts, nstart, t;
    bit seen;
    if (m_lm == 0) begin et = CMD_NEW; el = 1; end
    else if (st == ASSOC_UPD) begin et = CMD_UPD; el = alk; end
    else if (st == ASSOC_NEW && m_lm < MAX_LM) begin et = CMD_NEW; el = m_lm + 1; end
    else begin et = CMD_DROP; el = 0; end
    exp_starts = m_lm;
    nstart = 0;
    bus.obs_valid = 1'b1;
    t = 0;
    while (!bus.obs_ready && t < 20) begin step(); t++; end
    chk("obs_accept_ready", bus.obs_ready, 1);
    step();
    bus.obs_valid = 1'b0;
    m_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (bus.cmd_valid) seen = 1'b1;
      else if (bus.assoc_start) begin
        nstart++;
        chk("start_l_k", bus.l_k, nstart);
        step();
        repeat ($urandom_range(0, 3)) step();
        if (nstart == exp_starts) begin
          bus.assoc_status = st;
          bus.assoc_l_k    = ROW_LEN'(alk);
        end else begin
          bus.assoc_status = 2'($urandom);
          bus.assoc_l_k    = ROW_LEN'($urandom_range(0, 7));
        end
        bus.assoc_done = 1'b1;
        step();
        bus.assoc_done = 1'b0;
      end
    end
    chk("cmd_seen", seen, 1);
    chk("start_count", nstart, exp_starts);
    chk("cmd_type", bus.cmd_type, et);
    chk("cmd_l_k", bus.cmd_l_k, el);
    chk("issue_l_k", bus.l_k, el);
    got_type = bus.cmd_type;
    got_lk   = bus.cmd_l_k;
    step();
    repeat (rdy_dly) step();
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    m_ready = 1'b1;
    if (et == CMD_NEW) m_lm++;
  endtask

  task automatic do_clear();
    step();
    lm_clear = 1'b1;
    step();
    lm_clear = 1'b0;
    m_lm = 0;
    m_ready = 1'b0;
    step();
    m_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] gt;
    int gl, t;
    bus.obs_valid = 1'b0;
    bus.assoc_done = 1'b0;
    bus.assoc_status = ASSOC_WAIT;
    bus.assoc_l_k = '0;
    bus.cmd_ready = 1'b0;
    #12;
    chk("rst_obs_ready", bus.obs_ready, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_assoc_start", bus.assoc_start, 0);
    chk("rst_lm_num", lm_num, 0);
    chk("rst_map_full", map_full, 0);
    chk("rst_assoc_err", assoc_err, 0);
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    chk("rel_obs_ready_low", bus.obs_ready, 0);
    step();
    chk("rel_obs_ready_high", bus.obs_ready, 1);
    m_ready = 1'b1;
    check_en = 1'b1;

    // empty map seeds landmark 1 without a sweep
    run_obs(ASSOC_FAIL, 0, 1, gt, gl);
    chk("t1_type", gt, 1); chk("t1_lk", gl, 1); chk("t1_lm", lm_num, 1);
    run_obs(ASSOC_NEW, 0, 0, gt, gl);
    run_obs(ASSOC_NEW, 0, 2, gt, gl);
    chk("pre_t2_lm", lm_num, 3);
    run_obs(ASSOC_UPD, 2, 2, gt, gl);
    chk("t2_type", gt, 2); chk("t2_lk", gl, 2); chk("t2_lm", lm_num, 3);
    run_obs(ASSOC_NEW, 0, 1, gt, gl);
    chk("t3_type", gt, 1); chk("t3_lk", gl, 4); chk("t3_lm", lm_num, 4);
    chk("t4_full", map_full, 1);
    run_obs(ASSOC_NEW, 0, 0, gt, gl);
    chk("t4_type", gt, 3); chk("t4_lk", gl, 0); chk("t4_lm", lm_num, 4);
    run_obs(ASSOC_FAIL, 1, 5, gt, gl);
    chk("t5_type", gt, 3); chk("t5_lk", gl, 0);
    run_obs(ASSOC_WAIT, 1, 0, gt, gl);
    chk("wait_type", gt, 3);

    // stray assoc_done while idle must change nothing
    step();
    bus.assoc_done = 1'b1;
    step();
    bus.assoc_done = 1'b0;
    step();
    chk("idle_no_start", bus.assoc_start, 0);
    chk("idle_no_cmd", bus.cmd_valid, 0);

    do_clear();
    chk("clear_lm", lm_num, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      run_obs(2'($urandom_range(0, 3)), $urandom_range(1, (m_lm > 0) ? m_lm : 1),
              $urandom_range(0, 3), gt, gl);
    end

    // reset in the middle of a sweep
    if (m_lm == 0) run_obs(ASSOC_NEW, 0, 0, gt, gl);
    bus.obs_valid = 1'b1;
    step();
    bus.obs_valid = 1'b0;
    m_ready = 1'b0;
    t = 0;
    while (!bus.assoc_start && t < 20) begin step(); t++; end
    chk("mid_scan_started", bus.assoc_start, 1);
    step();
    check_en = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_obs_ready", bus.obs_ready, 0);
    chk("arst_l_k", bus.l_k, 0);
    chk("arst_cmd_valid", bus.cmd_valid, 0);
    chk("arst_cmd_type", bus.cmd_type, 0);
    chk("arst_lm_num", lm_num, 0);
    chk("arst_map_full", map_full, 0);
    m_lm = 0;
    m_ready = 1'b0;
    held = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
    chk("rel2_obs_ready_low", bus.obs_ready, 0);
    step();
    chk("rel2_obs_ready_high", bus.obs_ready, 1);
    m_ready = 1'b1;
    check_en = 1'b1;
    run_obs(ASSOC_UPD, 1, 1, gt, gl);
    chk("post_rst_type", gt, 1); chk("post_rst_lm", lm_num, 1);

`ifdef ASSOC_TIMEOUT_EN
    // no assoc_done at all: watchdog forces DROP and raises assoc_err
    bus.obs_valid = 1'b1;
    step();
    bus.obs_valid = 1'b0;
    m_ready = 1'b0;
    t = 0;
    while (!bus.cmd_valid && t < 3 * TIMEOUT_CYC) begin step(); t++; end
    chk("wd_cmd_seen", bus.cmd_valid, 1);
    chk("wd_window", int'(t >= TIMEOUT_CYC && t <= TIMEOUT_CYC + 3), 1);
    chk("wd_type", bus.cmd_type, 3);
    chk("wd_lk", bus.cmd_l_k, 0);
    chk("wd_err", assoc_err, 1);
    step();
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    m_ready = 1'b1;
    step();
    chk("wd_err_sticky", assoc_err, 1);
`endif

    step();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
